// File: rtl/fmul_arbiter.sv
// rtl/fmul_arbiter.sv - round-robin arbiter sharing one pipelined FP multiplier among NREQ requesters
module fmul_arbiter #(
  parameter int NREQ          = 4,
  parameter int precision_LEN = 64,
  parameter int MUL_LAT       = 1
) (
  input  logic                            clk,
  input  logic                            arst,
  input  logic [NREQ-1:0]                 req_valid,
  output logic [NREQ-1:0]                 req_ready,
  input  logic [NREQ*precision_LEN-1:0]   req_a,
  input  logic [NREQ*precision_LEN-1:0]   req_b,
  input  logic                            hold,
  output logic                            mul_enable,
  output logic [precision_LEN-1:0]        mul_a,
  output logic [precision_LEN-1:0]        mul_b,
  input  logic [precision_LEN-1:0]        mul_result,
  input  logic                            mul_valid,
  input  logic [2:0]                      mul_flags,
  output logic [NREQ-1:0]                 rsp_valid,
  output logic [precision_LEN-1:0]        rsp_result,
  output logic [2:0]                      rsp_flags,
  output logic [2:0]                      inflight,
  output logic                            err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  logic [IW-1:0]       r_last_grant;
  logic [MUL_LAT-1:0]  r_pipe_vld;
  logic [IW-1:0]       r_pipe_tag   [MUL_LAT];
  logic [2:0]          r_pipe_flags [MUL_LAT];
  logic [2:0]          r_inflight;
  logic                r_err;

  logic                w_found;
  logic [IW-1:0]       w_win;
  logic [IW-1:0]       w_cand;
  logic                w_grant;
  logic                w_out_vld;
  logic                w_rsp;

  // Round-robin search starting one past the last winner; first valid requester wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = IW'((int'(r_last_grant) + k) % NREQ);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  // A grant needs a winner, no hold, and the block out of reset.
  assign w_grant    = w_found & ~hold & ~arst;
  assign req_ready  = w_grant ? (ONE << w_win) : '0;
  assign mul_enable = w_grant;
  assign mul_a      = w_grant ? req_a[w_win*precision_LEN +: precision_LEN] : '0;
  assign mul_b      = w_grant ? req_b[w_win*precision_LEN +: precision_LEN] : '0;

  // Pipeline output lines up with the multiplier's valid MUL_LAT cycles after issue.
  assign w_out_vld  = r_pipe_vld[MUL_LAT-1];
  assign w_rsp      = w_out_vld & mul_valid;
  assign rsp_valid  = w_rsp ? (ONE << r_pipe_tag[MUL_LAT-1]) : '0;
  assign rsp_result = w_rsp ? mul_result : '0;
  assign rsp_flags  = w_rsp ? r_pipe_flags[MUL_LAT-1] : 3'b000;
  assign inflight   = r_inflight;
  assign err        = r_err;

  // Round-robin pointer moves only on an actual grant.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_last_grant <= IW'(NREQ - 1);
    end else if (w_grant) begin
      r_last_grant <= w_win;
    end
  end

  // Tag/flag shift pipeline tracking each issued operation until its result returns.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_pipe_vld <= '0;
      for (int k = 0; k < MUL_LAT; k++) begin
        r_pipe_tag[k]   <= '0;
        r_pipe_flags[k] <= 3'b000;
      end
    end else begin
      r_pipe_vld[0]   <= w_grant;
      r_pipe_tag[0]   <= w_grant ? w_win : '0;
      r_pipe_flags[0] <= w_grant ? mul_flags : 3'b000;
      for (int k = 1; k < MUL_LAT; k++) begin
        r_pipe_vld[k]   <= r_pipe_vld[k-1];
        r_pipe_tag[k]   <= r_pipe_tag[k-1];
        r_pipe_flags[k] <= r_pipe_flags[k-1];
      end
    end
  end

  // Outstanding count: +1 on issue, -1 when a tag leaves the pipeline (delivered or dropped).
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_inflight <= 3'd0;
    end else begin
      case ({w_grant, w_out_vld})
        2'b10:   r_inflight <= r_inflight + 3'd1;
        2'b01:   r_inflight <= r_inflight - 3'd1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Sticky error when the multiplier's valid disagrees with the expected return slot.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_err <= 1'b0;
    end else if (mul_valid ^ w_out_vld) begin
      r_err <= 1'b1;
    end
  end

endmodule

// File: doc/fmul_arbiter.md
FMUL_ARBITER -- requirements
Module: fmul_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, number of requesters sharing one multiplier (2..8).
REQ-002 The block SHALL have parameter precision_LEN, default 64, operand/result width.
REQ-003 The block SHALL have parameter MUL_LAT, default 1, multiplier enable-to-valid latency in cycles (1..4).
REQ-004 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 The block SHALL have port arst  input  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have port req_valid  input  NREQ  per-requester operation request.
REQ-007 The block SHALL have port req_ready  output  NREQ  per-requester accept (one-hot or zero).
REQ-008 The block SHALL have port req_a  input  NREQ*precision_LEN  operand A, requester i at slice i.
REQ-009 The block SHALL have port req_b  input  NREQ*precision_LEN  operand B, requester i at slice i.
REQ-010 The block SHALL have port hold  input  1  suppress new grants; in-flight operations complete.
REQ-011 The block SHALL have port mul_enable, mul_a, mul_b  output  1/precision_LEN/precision_LEN  multiplier issue.
REQ-012 The block SHALL have port mul_result, mul_valid  input  precision_LEN/1  multiplier registered result and valid.
REQ-013 The block SHALL have port mul_flags  input  3  {Exception,Overflow,Underflow}, combinational from current mul_a/mul_b.
REQ-014 The block SHALL have port rsp_valid  output  NREQ  one-hot result strobe, one cycle, no backpressure.
REQ-015 The block SHALL have port rsp_result, rsp_flags  output  precision_LEN/3  result and flags of the strobed response.
REQ-016 The block SHALL have port inflight  output  3  count of issued, unreturned operations.
REQ-017 The block SHALL have port err  output  1  sticky protocol error.

Function
REQ-018 Grant SHALL be round-robin: search starts at requester (last_grant+1) mod NREQ; pointer resets to requester 0 highest priority.
REQ-019 At most one grant per cycle; req_ready[i]=1 only when req_valid[i]=1, hold=0, and i wins arbitration (combinational).
REQ-020 Grant cycle N: mul_enable=1, mul_a/mul_b driven combinationally from winner's slices; otherwise mul_enable=0, mul_a/mul_b=0.
REQ-021 last_grant SHALL update only in a cycle with a grant; unchanged when no request or hold=1.
REQ-022 At end of cycle N the winner index and mul_flags SHALL enter a MUL_LAT-deep tag/flag shift pipeline with a valid bit.
REQ-023 In cycle N+MUL_LAT, when pipeline output valid and mul_valid=1: rsp_valid[tag]=1, rsp_result=mul_result, rsp_flags=pipelined flags.
REQ-024 When no response: rsp_valid=0, rsp_result=0, rsp_flags=0.
REQ-025 Throughput SHALL be one operation per cycle; back-to-back grants to the same requester allowed if it alone requests.
REQ-026 inflight SHALL increment on grant, decrement on response, unchanged when both occur in the same cycle; never exceeds MUL_LAT.
REQ-027 err SHALL set when mul_valid and pipeline-output valid disagree in any cycle; it is cleared only by reset.
REQ-028 On mismatch, mul_valid without pipeline valid SHALL be dropped (no rsp_valid); pipeline valid without mul_valid SHALL drop that tag.
REQ-029 hold rising mid-operation SHALL not affect in-flight responses; hold falling resumes arbitration from stored pointer.
REQ-030 Requester deasserting req_valid before grant SHALL simply lose its turn; no state retained for it.

Reset
REQ-031 While arst=1: req_ready=0, mul_enable=0, rsp_valid=0, rsp_result=0, rsp_flags=0, inflight=0, err=0, last_grant=NREQ-1, pipeline valids cleared.
REQ-032 Reset asserted with operations in flight SHALL discard them; no rsp_valid after deassertion for pre-reset grants.
REQ-033 First cycle after arst deasserts SHALL allow a grant.

Verification
REQ-034 Single request: req_valid=0001, a=2.0, b=3.0 (doubles) -> req_ready=0001 cycle N, rsp_valid=0001, rsp_result=6.0 (0x4018000000000000), flags=000 at N+MUL_LAT.
REQ-035 All four request continuously from reset -> grants 0,1,2,3,0 on consecutive cycles, responses in same order, inflight steady at MUL_LAT.
REQ-036 Requester 2 operand with exponent all ones -> rsp_flags[2] (Exception)=1 on requester 2's strobe, others 000.
REQ-037 hold=1 for 3 cycles with all requesting, one operation in flight -> no req_ready, in-flight response still delivered, next grant continues rotation.
REQ-038 arst pulse one cycle after a grant -> all outputs zero, no response for that grant, err=0.
REQ-039 Force mul_valid=1 with empty pipeline -> err=1 sticky, rsp_valid=0.
